// File: rtl/imu_disp_pkg.sv
// Shared definitions for the IMU channel display: mode encodings,
// saturating magnitude and a ceiling-log2 helper for parameter math.
package imu_disp_pkg;

    localparam logic [1:0] MODE_LIVE   = 2'd0;
    localparam logic [1:0] MODE_PEAK   = 2'd1;
    localparam logic [1:0] MODE_FREEZE = 2'd2;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // x holds a w-bit two's complement value in its low bits; the most
    // negative value saturates to the largest positive magnitude.
    function automatic logic [63:0] abs_sat(input logic [63:0] x, input int w);
        logic [63:0] mask;
        logic [63:0] xm;
        logic [63:0] min_neg;
        mask    = (64'd1 << w) - 64'd1;
        xm      = x & mask;
        min_neg = 64'd1 << (w - 1);
        if ((xm & min_neg) == 64'd0) begin
            return xm;
        end else if (xm == min_neg) begin
            return min_neg - 64'd1;
        end else begin
            return (~xm + 64'd1) & mask;
        end
    endfunction

endpackage

// File: rtl/imu_channel_display_rise_edge.sv
// Rising-edge detector for a debounced button level; the history register
// resets high so a button held through reset produces no edge.
module rise_edge (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_btn,
    output logic o_edge
);

    logic r_prev;

    // Previous-cycle button level.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_prev <= 1'b1;
        end else begin
            r_prev <= i_btn;
        end
    end

    assign o_edge = i_btn & ~r_prev;

endmodule

// File: rtl/imu_channel_display.sv
// Selects one signed IMU channel and shows its sign and magnitude on an LED
// bar, with LIVE, PEAK-hold and FREEZE display modes.
module imu_channel_display
    import imu_disp_pkg::*;
#(
    parameter  int NUM_CH = 6,
    parameter  int DATA_W = 16,
    parameter  int LED_W  = 8,
    localparam int SEL_W  = clog2(NUM_CH),
    localparam int LVL_W  = clog2(LED_W)
) (
    input  logic                       clk_50mhz,
    input  logic                       reset,
    input  logic                       btn_next,
    input  logic                       btn_mode,
    input  logic                       sample_valid,
    input  logic [NUM_CH*DATA_W-1:0]   samples,
    output logic [LED_W-1:0]           led,
    output logic [SEL_W-1:0]           sel_ch,
    output logic [1:0]                 mode
);

    logic              w_next_edge;
    logic              w_mode_edge;
    logic [SEL_W-1:0]  r_sel;
    logic [1:0]        r_mode;
    logic [1:0]        w_mode_nxt;
    logic [DATA_W-1:0] r_held;
    logic [DATA_W-1:0] w_held_nxt;
    logic [DATA_W-1:0] w_x;
    logic [DATA_W-2:0] w_mag_x;
    logic [DATA_W-2:0] w_mag_held;
    logic [LVL_W-1:0]  w_level;
    logic [LED_W-2:0]  w_bar;
    logic [LED_W-1:0]  r_led;

    rise_edge u_next_edge (
        .i_clk   (clk_50mhz),
        .i_reset (reset),
        .i_btn   (btn_next),
        .o_edge  (w_next_edge)
    );

    rise_edge u_mode_edge (
        .i_clk   (clk_50mhz),
        .i_reset (reset),
        .i_btn   (btn_mode),
        .o_edge  (w_mode_edge)
    );

    assign w_x        = samples[int'(r_sel)*DATA_W +: DATA_W];
    assign w_mag_x    = (DATA_W-1)'(abs_sat({{(64-DATA_W){1'b0}}, w_x}, DATA_W));
    assign w_mag_held = (DATA_W-1)'(abs_sat({{(64-DATA_W){1'b0}}, r_held}, DATA_W));
    assign w_level    = LVL_W'(w_mag_held >> (DATA_W - 1 - LVL_W));

    // Next mode: advance on a button edge, fall back to LIVE from the unused code.
    always_comb begin
        w_mode_nxt = MODE_LIVE;
        if (w_mode_edge) begin
            case (r_mode)
                MODE_LIVE: w_mode_nxt = MODE_PEAK;
                MODE_PEAK: w_mode_nxt = MODE_FREEZE;
                default:   w_mode_nxt = MODE_LIVE;
            endcase
        end else begin
            case (r_mode)
                MODE_LIVE, MODE_PEAK, MODE_FREEZE: w_mode_nxt = r_mode;
                default:                           w_mode_nxt = MODE_LIVE;
            endcase
        end
    end

    // Held value: channel change beats everything, then mode-entry rules, then capture.
    always_comb begin
        w_held_nxt = r_held;
        if (w_next_edge) begin
            w_held_nxt = '0;
        end else if (w_mode_edge && (w_mode_nxt == MODE_PEAK)) begin
            w_held_nxt = sample_valid ? w_x : '0;
        end else if (w_mode_edge && (w_mode_nxt == MODE_FREEZE)) begin
            w_held_nxt = r_held;
        end else if (sample_valid) begin
            case (w_mode_nxt)
                MODE_LIVE: w_held_nxt = w_x;
                MODE_PEAK: w_held_nxt = (w_mag_x > w_mag_held) ? w_x : r_held;
                default:   w_held_nxt = r_held;
            endcase
        end else begin
            w_held_nxt = r_held;
        end
    end

    // Thermometer bar: the lowest `level` LEDs light.
    always_comb begin
        w_bar = '0;
        for (int k = 0; k < LED_W - 1; k++) begin
            w_bar[k] = (k < int'(w_level));
        end
    end

    // State and output registers.
    always_ff @(posedge clk_50mhz) begin
        if (reset) begin
            r_sel  <= '0;
            r_mode <= MODE_LIVE;
            r_held <= '0;
            r_led  <= '0;
        end else begin
            if (w_next_edge) begin
                r_sel <= (r_sel == SEL_W'(NUM_CH - 1)) ? '0 : r_sel + SEL_W'(1);
            end else begin
                r_sel <= r_sel;
            end
            r_mode <= w_mode_nxt;
            r_held <= w_held_nxt;
            r_led  <= {r_held[DATA_W-1], w_bar};
        end
    end

    assign led    = r_led;
    assign sel_ch = r_sel;
    assign mode   = r_mode;

endmodule
